// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Owns the program counter, drives the combinational big-endian instruction
//   memory, and buffers fetched {pc, instr} pairs in a small in-order queue
//   that is handed to decode over a valid/ready handshake. A branch redirect
//   flushes the queue and restarts fetch at the target.
//
//   Optional feature macro: IF_FAULT_EN
//     When defined, fetching from a misaligned pc or from beyond IMEM_BYTES
//     latches 'fault' and stops fetching until a redirect or reset.
//     When undefined, no address checks are made and 'fault' is tied 0.
//
// Ports
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   imem_addr      out  64  byte address being fetched (the pc)
//   imem_data      in   32  instruction word at imem_addr (same cycle)
//   redirect_valid in   1   one-cycle branch pulse
//   redirect_pc    in   64  branch target byte address
//   dec_valid      out  1   queue head valid
//   dec_ready      in   1   decode accepts the head
//   dec_instr      out  32  head instruction word
//   dec_pc         out  64  head instruction byte address
//   fetch_count    out  16  instructions accepted by decode (wraps)
//   fault          out  1   fetch fault latched
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int          QDEPTH     = 2,
  parameter int          IMEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [63:0] dec_pc,
  output logic [15:0] fetch_count,
  output logic        fault
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  // Reject configurations the pointer arithmetic cannot support.
  generate
    if (QDEPTH < 2 || QDEPTH > 8 || (QDEPTH & (QDEPTH - 1)) != 0 || IMEM_BYTES < 4) begin : g_bad_params
      $error("fetch_sequencer: QDEPTH must be a power of two in 2..8 and IMEM_BYTES >= 4");
    end
  endgenerate

`ifdef IF_FAULT_EN
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HOLD, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HOLD} state_t;
`endif

  state_t          state_reg, state_next;
  logic [63:0]     pc_reg;
  logic [PW-1:0]   head_reg, tail_reg;
  logic [CW-1:0]   count_reg;
  logic [15:0]     fetch_count_reg;

  logic [63:0]     pc_mem    [QDEPTH];
  logic [31:0]     instr_mem [QDEPTH];

  logic            deq;
  logic            slot;
  logic            enq;
  logic            fault_set;
  logic            addr_bad;

  assign dec_valid = (count_reg != '0);
  assign deq       = dec_valid & dec_ready;
  // A full queue still has room this cycle if the head leaves.
  assign slot      = (count_reg < FULL) | deq;

`ifdef IF_FAULT_EN
  logic [64:0] last_byte;
  assign last_byte = {1'b0, pc_reg} + 65'd3;
  assign addr_bad  = (pc_reg[1:0] != 2'b00) || (last_byte >= 65'(IMEM_BYTES));
`else
  assign addr_bad  = 1'b0;
`endif

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_next = state_reg;
    if (redirect_valid) begin
      state_next = S_RUN;
    end else begin
      case (state_reg)
        S_BOOT: state_next = S_RUN;
        S_RUN: begin
          if (!slot) begin
            state_next = S_HOLD;
          end else if (addr_bad) begin
`ifdef IF_FAULT_EN
            state_next = S_FAULT;
`else
            state_next = S_RUN;
`endif
          end
        end
        S_HOLD: begin
          if (deq) state_next = S_RUN;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    enq       = 1'b0;
    fault_set = 1'b0;
    if (!redirect_valid && state_reg == S_RUN && slot) begin
      if (addr_bad) fault_set = 1'b1;
      else          enq       = 1'b1;
    end
  end

  // ---------------------------------------------------------------------- pc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else if (redirect_valid) begin
      pc_reg <= redirect_pc;
    end else if (enq) begin
      pc_reg <= pc_reg + 64'd4;
    end
  end

  // ----------------------------------------------------------- queue control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (redirect_valid) begin
      // Flush; a concurrent deq is already accounted for in fetch_count.
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (enq) tail_reg <= tail_reg + 1'b1;
      if (deq) head_reg <= head_reg + 1'b1;
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Queue storage: plain registers, no reset needed since output is gated.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail_reg]    <= pc_reg;
      instr_mem[tail_reg] <= imem_data;
    end
  end

  // ------------------------------------------------------------- fetch count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_reg <= 16'd0;
    end else if (deq) begin
      fetch_count_reg <= fetch_count_reg + 16'd1;
    end
  end

  // ------------------------------------------------------------------- fault
`ifdef IF_FAULT_EN
  logic fault_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_reg <= 1'b0;
    end else if (redirect_valid) begin
      fault_reg <= 1'b0;
    end else if (fault_set) begin
      fault_reg <= 1'b1;
    end
  end
  assign fault = fault_reg;
`else
  assign fault = 1'b0;
`endif

  assign imem_addr   = pc_reg;
  assign fetch_count = fetch_count_reg;
  // Head is forced to zero when empty so no flushed entry is ever visible.
  assign dec_pc      = dec_valid ? pc_mem[head_reg]    : 64'd0;
  assign dec_instr   = dec_valid ? instr_mem[head_reg] : 32'd0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Randomized and directed stimulus for fetch_sequencer, checked every cycle
//   against a transaction-level model (a queue of {pc, instr} entries, a pc
//   value and a few flags). Memory is a byte array read big-endian.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam logic [63:0] RESET_PC = 64'd0;
  localparam int QDEPTH = 2;
  localparam int IMEM_BYTES = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
  logic [15:0] fetch_count;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_PC  (RESET_PC),
    .QDEPTH    (QDEPTH),
    .IMEM_BYTES(IMEM_BYTES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc),
    .fetch_count   (fetch_count),
    .fault         (fault)
  );

  // ------------------------------------------------------------ memory model
  logic [7:0] mem_bytes [IMEM_BYTES];

  function automatic logic [7:0] byte_at(input logic [63:0] a);
    if (a < 64'(IMEM_BYTES)) return mem_bytes[a[5:0]];
    return a[7:0] ^ 8'h5C;
  endfunction

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return {byte_at(a), byte_at(a + 64'd1), byte_at(a + 64'd2), byte_at(a + 64'd3)};
  endfunction

  always_comb imem_data = word_at(imem_addr);

  // --------------------------------------------------------- reference model
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      m_q[$];
  logic [63:0] m_pc;
  logic [15:0] m_count;
  bit          m_boot;     // idle cycle after reset still pending
  bit          m_waiting;  // queue was full; resume after a deq
  bit          m_fault;

  function automatic bit addr_illegal(input logic [63:0] a);
`ifdef IF_FAULT_EN
    logic [64:0] last;
    last = {1'b0, a} + 65'd3;
    return (a[1:0] != 2'b00) || (last >= 65'(IMEM_BYTES));
`else
    return (a == 64'd1) && (a == 64'd2);  // never true: no address checks
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc      = RESET_PC;
    m_count   = 16'd0;
    m_boot    = 1'b1;
    m_waiting = 1'b0;
    m_fault   = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs held across it.
  task automatic model_edge();
    bit had_room;
    bit took;
    had_room = (m_q.size() < QDEPTH);
    took     = (m_q.size() > 0) && dec_ready;
    if (took) begin
      $display("deq pc=%h instr=%h count=%0d", m_q[0].pc, m_q[0].instr, m_count + 16'd1);
      void'(m_q.pop_front());
      m_count = m_count + 16'd1;
    end
    if (redirect_valid) begin
      m_q.delete();
      m_pc      = redirect_pc;
      m_boot    = 1'b0;
      m_waiting = 1'b0;
      m_fault   = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_fault) begin
      // no fetch while faulted
    end else if (m_waiting) begin
      if (took) m_waiting = 1'b0;
    end else if (had_room || took) begin
      if (addr_illegal(m_pc)) begin
        m_fault = 1'b1;
      end else begin
        m_q.push_back('{pc: m_pc, instr: word_at(m_pc)});
        m_pc = m_pc + 64'd4;
      end
    end else begin
      m_waiting = 1'b1;
    end
  endtask

  // ----------------------------------------------------------------- checker
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("dec_valid", 64'(dec_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check_eq("dec_pc", dec_pc, m_q[0].pc);
      check_eq("dec_instr", 64'(dec_instr), 64'(m_q[0].instr));
    end
    check_eq("fetch_count", 64'(fetch_count), 64'(m_count));
    check_eq("fault", 64'(fault), 64'(m_fault));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(dec_valid), 64'd0);
    check_eq({tag, "_instr"}, 64'(dec_instr), 64'd0);
    check_eq({tag, "_pc"}, dec_pc, 64'd0);
    check_eq({tag, "_count"}, 64'(fetch_count), 64'd0);
    check_eq({tag, "_fault"}, 64'(fault), 64'd0);
    check_eq({tag, "_addr"}, imem_addr, RESET_PC);
  endtask

  // One clock: model follows the edge, then compare 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [63:0] rpc);
    dec_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic redirect_to(input logic rdy, input logic [63:0] target);
    drive(rdy, 1'b1, target);
    step();
    redirect_valid = 1'b0;
  endtask

  // Asynchronous reset away from the clock edge, held over two edges.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs(tag);
    redirect_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < IMEM_BYTES; i++) mem_bytes[i] = 8'($urandom);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 64'd0);
    model_reset();
    #3;
    check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T1: free-running fetch from reset
    dec_ready = 1'b1;
    step();
    check_eq("t1_boot_idle", 64'(dec_valid), 64'd0);
    step();
    check_eq("t1_first_pc", dec_pc, RESET_PC);
    check_eq("t1_first_instr", 64'(dec_instr), 64'(word_at(RESET_PC)));
    repeat (4) step();
    check_eq("t1_count4", 64'(fetch_count), 64'd4);

    // T2: stall decode until the queue fills, then drain
    dec_ready = 1'b0;
    repeat (6) step();
    dec_ready = 1'b1;
    repeat (4) step();

    // T3: redirect while full
    dec_ready = 1'b0;
    repeat (4) step();
    redirect_to(1'b0, 64'd36);
    check_eq("t3_flush_valid", 64'(dec_valid), 64'd0);
    step();
    check_eq("t3_target_pc", dec_pc, 64'd36);
    dec_ready = 1'b1;
    repeat (3) step();

    // T4: redirect with a concurrent deq
    check_eq("t4_pre_valid", 64'(dec_valid), 64'd1);
    redirect_to(1'b1, 64'd20);
    check_eq("t4_empty_after", 64'(dec_valid), 64'd0);
    repeat (3) step();

    // T5: reset mid-stream with two entries queued
    dec_ready = 1'b0;
    repeat (4) step();
    pulse_reset("t5_rst");
    dec_ready = 1'b1;
    step();
    step();
    check_eq("t5_restart_pc", dec_pc, RESET_PC);
    repeat (2) step();

    // T6: out-of-range / misaligned target, then recover
    redirect_to(1'b1, 64'd62);
    repeat (3) step();
    redirect_to(1'b1, 64'd0);
    step();
    check_eq("t6_recover_pc", dec_pc, 64'd0);
    redirect_to(1'b1, 64'd60);
    repeat (4) step();
    redirect_to(1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    repeat (4) step();

    // Randomized phase
    for (int cyc = 0; cyc < 600; cyc++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      dec_ready = ($urandom_range(0, 99) < 70);
      if (r < 1) begin
        pulse_reset("rnd_rst");
      end else if (r < 9) begin
        int unsigned k;
        logic [63:0] tgt;
        k = $urandom_range(0, 9);
        if (k < 7)      tgt = 64'($urandom_range(0, 15)) << 2;
        else if (k < 8) tgt = 64'($urandom_range(0, 63));
        else if (k < 9) tgt = 64'hFFFF_FFFF_FFFF_FFF8;
        else            tgt = 64'd56;
        redirect_to(dec_ready, tgt);
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
